// File: rtl/intersection_conflict_monitor_pkg.sv
// conflict_monitor_pkg: shared constants for the intersection conflict monitor.
//   - fault code encodings driven on out_fault_code
//   - lamp bit indices inside a 5-bit lamp vector {ped, left, yellow, green, red}
//   - monitor state encoding
// Optional feature macro used by the design: CONFLICT_MONITOR_YELLOW_CHECK_EN
package conflict_monitor_pkg;

  localparam logic [2:0] FC_NONE         = 3'd0;
  localparam logic [2:0] FC_CONFLICT     = 3'd1;
  localparam logic [2:0] FC_MULTI_LAMP   = 3'd2;
  localparam logic [2:0] FC_DARK         = 3'd3;
  localparam logic [2:0] FC_SHORT_YELLOW = 3'd4;

  localparam int LAMP_RED        = 0;
  localparam int LAMP_GREEN      = 1;
  localparam int LAMP_YELLOW     = 2;
  localparam int LAMP_LEFT_TURN  = 3;
  localparam int LAMP_PEDESTRIAN = 4;

  typedef enum logic [1:0] {
    ST_MONITOR = 2'd0,
    ST_PENDING = 2'd1,
    ST_FAULT   = 2'd2
  } state_t;

endpackage

// File: rtl/intersection_conflict_monitor_if.sv
// intersection_conflict_monitor_if: bundles the lamp inputs and fault outputs
// of the conflict monitor.
//   in_lights_a / in_lights_b : lamp vectors of approach A / B
//   out_issue                 : fault latched
//   out_fault_code            : captured fault class
//   out_fault_approach        : captured approach (0 = A, 1 = B)
//   dbg_state                 : current monitor state, for observation only
// Handshake: there is no valid/ready pair; the monitor samples both lamp
// vectors on every clock and the outputs are level signals that are always valid.
interface intersection_conflict_monitor_if;
  import conflict_monitor_pkg::*;

  logic [4:0] in_lights_a;
  logic [4:0] in_lights_b;
  logic       out_issue;
  logic [2:0] out_fault_code;
  logic       out_fault_approach;
  state_t     dbg_state;

  modport master (
    output in_lights_a, in_lights_b,
    input  out_issue, out_fault_code, out_fault_approach, dbg_state
  );

  modport slave (
    input  in_lights_a, in_lights_b,
    output out_issue, out_fault_code, out_fault_approach, dbg_state
  );

endinterface

// File: rtl/intersection_conflict_monitor_approach_checker.sv
// approach_checker: per-approach checks on one registered lamp sample.
//   clk_i, rst_i       : clock, synchronous active-high reset
//   sample_i[4:0]      : registered lamp vector {ped, left, yellow, green, red}
//   go_o               : approach shows any right-of-way lamp
//   multi_o            : illegal lamp combination
//   dark_o             : all-dark run longer than DARK_MAX_TICKS
//   short_yellow_o     : yellow-only -> red-only with too short a yellow
// The yellow counter and short-yellow event exist only when
// CONFLICT_MONITOR_YELLOW_CHECK_EN is defined; otherwise short_yellow_o is 0.
module approach_checker
  import conflict_monitor_pkg::*;
#(
  parameter logic [31:0] DARK_MAX_TICKS   = 32'd50000000,
  parameter logic [31:0] MIN_YELLOW_TICKS = 32'd250000000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [4:0] sample_i,
  output logic       go_o,
  output logic       multi_o,
  output logic       dark_o,
  output logic       short_yellow_o
);

  localparam logic [31:0] CNT_MAX = 32'hFFFF_FFFF;

  logic        is_dark;
  logic [31:0] dark_q, dark_d;

  assign go_o    = |sample_i[LAMP_PEDESTRIAN:LAMP_GREEN];
  assign multi_o = (sample_i[LAMP_RED] && go_o) ||
                   (sample_i[LAMP_GREEN] && sample_i[LAMP_YELLOW]);
  assign is_dark = (sample_i == 5'b00000);

  // dark_q holds the number of dark samples before the current one, so the
  // current dark sample is number dark_q+1 and exceeds the limit when
  // dark_q >= DARK_MAX_TICKS.
  always_comb begin
    dark_d = 32'd0;
    if (is_dark) begin
      dark_d = (dark_q == CNT_MAX) ? dark_q : dark_q + 32'd1;
    end
  end

  assign dark_o = is_dark && (dark_q >= DARK_MAX_TICKS);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dark_q <= 32'd0;
    end else begin
      dark_q <= dark_d;
    end
  end

`ifdef CONFLICT_MONITOR_YELLOW_CHECK_EN
  logic        yellow_only;
  logic        red_only;
  logic        prev_yellow_q;
  logic [31:0] yel_q, yel_d;

  assign yellow_only = (sample_i == (5'b00001 << LAMP_YELLOW));
  assign red_only    = (sample_i == (5'b00001 << LAMP_RED));

  // Counts consecutive yellow-only samples; any other sample clears it.
  always_comb begin
    yel_d = 32'd0;
    if (yellow_only) begin
      yel_d = (yel_q >= MIN_YELLOW_TICKS) ? yel_q : yel_q + 32'd1;
    end
  end

  // yel_q still holds the completed yellow run length on the red-only sample.
  assign short_yellow_o = prev_yellow_q && red_only && (yel_q < MIN_YELLOW_TICKS);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      yel_q         <= 32'd0;
      prev_yellow_q <= 1'b0;
    end else begin
      yel_q         <= yel_d;
      prev_yellow_q <= yellow_only;
    end
  end
`else
  logic unused_yellow_cfg;
  assign unused_yellow_cfg = ^MIN_YELLOW_TICKS;
  assign short_yellow_o    = 1'b0;
`endif

endmodule

// File: rtl/intersection_conflict_monitor.sv
// intersection_conflict_monitor: watchdog on the lamp outputs of the two
// approach state machines. Latches a fault on conflicting right-of-way,
// illegal lamp combination, over-long dark approach or (optionally) short
// yellow, and holds it until reset.
//   in_clock : clock
//   in_reset : synchronous active-high reset, the only exit from FAULT
//   mon      : slave side of intersection_conflict_monitor_if
//              (lamp inputs in, out_issue / out_fault_code /
//               out_fault_approach / dbg_state out)
// Optional feature macro: CONFLICT_MONITOR_YELLOW_CHECK_EN enables the
// short-yellow check (fault code 4).
module intersection_conflict_monitor
  import conflict_monitor_pkg::*;
#(
  parameter logic [31:0] FILTER_TICKS     = 32'd3,
  parameter logic [31:0] DARK_MAX_TICKS   = 32'd50000000,
  parameter logic [31:0] MIN_YELLOW_TICKS = 32'd250000000
) (
  input  logic                           in_clock,
  input  logic                           in_reset,
  intersection_conflict_monitor_if.slave mon
);

  // A filter length of 0 behaves as 1.
  localparam logic [31:0] FILTER_EFF = (FILTER_TICKS == 32'd0) ? 32'd1 : FILTER_TICKS;

  logic [4:0] lights_a_q, lights_b_q;

  logic go_a, go_b, multi_a, multi_b, dark_a, dark_b, sy_a, sy_b;
  logic conflict, persist, short_ev;

  state_t      state_q, state_d;
  logic [31:0] filter_q, filter_d;

  logic       issue_q, issue_d;
  logic [2:0] code_q, code_d;
  logic       appr_q, appr_d;
  logic [2:0] cap_code;
  logic       cap_appr;

  // Input register: every check works on these samples.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      lights_a_q <= 5'd0;
      lights_b_q <= 5'd0;
    end else begin
      lights_a_q <= mon.in_lights_a;
      lights_b_q <= mon.in_lights_b;
    end
  end

  approach_checker #(
    .DARK_MAX_TICKS  (DARK_MAX_TICKS),
    .MIN_YELLOW_TICKS(MIN_YELLOW_TICKS)
  ) u_chk_a (
    .clk_i         (in_clock),
    .rst_i         (in_reset),
    .sample_i      (lights_a_q),
    .go_o          (go_a),
    .multi_o       (multi_a),
    .dark_o        (dark_a),
    .short_yellow_o(sy_a)
  );

  approach_checker #(
    .DARK_MAX_TICKS  (DARK_MAX_TICKS),
    .MIN_YELLOW_TICKS(MIN_YELLOW_TICKS)
  ) u_chk_b (
    .clk_i         (in_clock),
    .rst_i         (in_reset),
    .sample_i      (lights_b_q),
    .go_o          (go_b),
    .multi_o       (multi_b),
    .dark_o        (dark_b),
    .short_yellow_o(sy_b)
  );

  assign conflict = go_a && go_b;
  assign persist  = conflict || multi_a || multi_b || dark_a || dark_b;
  assign short_ev = sy_a || sy_b;

  // State register, filter count and captured outputs.
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      state_q  <= ST_MONITOR;
      filter_q <= 32'd0;
      issue_q  <= 1'b0;
      code_q   <= FC_NONE;
      appr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      filter_q <= filter_d;
      issue_q  <= issue_d;
      code_q   <= code_d;
      appr_q   <= appr_d;
    end
  end

  // Next state. The filter count is the number of violating samples seen so
  // far; FAULT is entered on the edge that would make it reach FILTER_EFF,
  // which puts out_issue FILTER_EFF+1 edges after the first violating input.
  always_comb begin
    state_d  = state_q;
    filter_d = filter_q;
    case (state_q)
      ST_MONITOR: begin
        if (short_ev) begin
          state_d = ST_FAULT;
        end else if (persist) begin
          if (FILTER_EFF == 32'd1) begin
            state_d = ST_FAULT;
          end else begin
            state_d  = ST_PENDING;
            filter_d = 32'd1;
          end
        end
      end
      ST_PENDING: begin
        if (short_ev) begin
          state_d = ST_FAULT;
        end else if (!persist) begin
          state_d  = ST_MONITOR;
          filter_d = 32'd0;
        end else if (({1'b0, filter_q} + 33'd1) >= {1'b0, FILTER_EFF}) begin
          state_d = ST_FAULT;
        end else begin
          filter_d = filter_q + 32'd1;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d  = ST_MONITOR;
        filter_d = 32'd0;
      end
    endcase
  end

  // Highest-priority active violation: conflict, multi-lamp, dark, short
  // yellow; A before B within a class.
  always_comb begin
    cap_code = FC_NONE;
    cap_appr = 1'b0;
    if (conflict) begin
      cap_code = FC_CONFLICT;
    end else if (multi_a) begin
      cap_code = FC_MULTI_LAMP;
    end else if (multi_b) begin
      cap_code = FC_MULTI_LAMP;
      cap_appr = 1'b1;
    end else if (dark_a) begin
      cap_code = FC_DARK;
    end else if (dark_b) begin
      cap_code = FC_DARK;
      cap_appr = 1'b1;
    end else if (sy_a) begin
      cap_code = FC_SHORT_YELLOW;
    end else if (sy_b) begin
      cap_code = FC_SHORT_YELLOW;
      cap_appr = 1'b1;
    end
  end

  // Outputs only change on entry to FAULT; afterwards they are held.
  always_comb begin
    issue_d = issue_q;
    code_d  = code_q;
    appr_d  = appr_q;
    if ((state_q != ST_FAULT) && (state_d == ST_FAULT)) begin
      issue_d = 1'b1;
      code_d  = cap_code;
      appr_d  = cap_appr;
    end
  end

  assign mon.out_issue          = issue_q;
  assign mon.out_fault_code     = code_q;
  assign mon.out_fault_approach = appr_q;
  assign mon.dbg_state          = state_q;

endmodule

// File: tb/tb_intersection_conflict_monitor.sv
module tb_intersection_conflict_monitor;
  import conflict_monitor_pkg::*;

  localparam logic [4:0] L_DARK = 5'b00000;
  localparam logic [4:0] L_R    = 5'b00001;
  localparam logic [4:0] L_G    = 5'b00010;
  localparam logic [4:0] L_Y    = 5'b00100;
  localparam logic [4:0] L_RG   = 5'b00011;
  localparam logic [4:0] L_RY   = 5'b00101;

`ifdef CONFLICT_MONITOR_YELLOW_CHECK_EN
  localparam bit YEL_EN = 1'b1;
`else
  localparam bit YEL_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic in_clock;
  logic in_reset;

  initial begin
    in_clock = 1'b0;
    forever #5 in_clock = ~in_clock;
  end

  intersection_conflict_monitor_if mon_if();

  intersection_conflict_monitor #(
    .FILTER_TICKS    (32'd3),
    .DARK_MAX_TICKS  (32'd8),
    .MIN_YELLOW_TICKS(32'd10)
  ) dut (
    .in_clock(in_clock),
    .in_reset(in_reset),
    .mon     (mon_if)
  );

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic [4:0] a;
    logic [4:0] b;
    int         edges;
    logic       issue;
    logic [2:0] code;
    logic       appr;
  } vec_t;

  vec_t vecs[$];
  logic [4:0] exp_q[$];

  int n_compared;
  int n_failed;

  task automatic add_vec(input logic rst, input logic [4:0] a, input logic [4:0] b,
                         input int edges, input logic issue, input logic [2:0] code,
                         input logic appr);
    vec_t v;
    v.rst = rst; v.a = a; v.b = b; v.edges = edges;
    v.issue = issue; v.code = code; v.appr = appr;
    vecs.push_back(v);
  endtask

  // ---------------- driver ----------------
  task automatic drive(input logic rst, input logic [4:0] a, input logic [4:0] b,
                       input int edges);
    in_reset = rst;
    mon_if.in_lights_a = a;
    mon_if.in_lights_b = b;
    repeat (edges) @(posedge in_clock);
    @(negedge in_clock);
  endtask

  // ---------------- scoreboard ----------------
  task automatic check_out(input string name);
    logic [4:0] exp_v;
    logic [4:0] act_v;
    exp_v = exp_q.pop_front();
    act_v = {mon_if.out_issue, mon_if.out_fault_code, mon_if.out_fault_approach};
    n_compared++;
    if (act_v !== exp_v) begin
      n_failed++;
      $display("FAIL %s: got issue/code/appr=%b/%0d/%b expected %b/%0d/%b",
               name, act_v[4], act_v[3:1], act_v[0], exp_v[4], exp_v[3:1], exp_v[0]);
    end
  endtask

  task automatic check_state(input string name, input state_t exp_s);
    n_compared++;
    if (mon_if.dbg_state !== exp_s) begin
      n_failed++;
      $display("FAIL %s: got state=%0d expected %0d", name, mon_if.dbg_state, exp_s);
    end
  endtask

  initial begin
    n_compared = 0;
    n_failed   = 0;
    in_reset = 1'b1;
    mon_if.in_lights_a = L_R;
    mon_if.in_lights_b = L_R;

    // Conflict: latched after edge 4, held after B returns to red.
    add_vec(1, L_R, L_R, 2, 0, FC_NONE, 0);
    add_vec(0, L_G, L_G, 3, 0, FC_NONE, 0);
    add_vec(0, L_G, L_G, 1, 1, FC_CONFLICT, 0);
    add_vec(0, L_G, L_R, 5, 1, FC_CONFLICT, 0);
    // Glitch rejection: 2-cycle conflict leaves no trace, 3-cycle latches.
    add_vec(1, L_G, L_R, 1, 0, FC_NONE, 0);
    add_vec(0, L_G, L_R, 3, 0, FC_NONE, 0);
    add_vec(0, L_G, L_G, 2, 0, FC_NONE, 0);
    add_vec(0, L_G, L_R, 4, 0, FC_NONE, 0);
    add_vec(0, L_G, L_G, 3, 0, FC_NONE, 0);
    add_vec(0, L_G, L_R, 1, 1, FC_CONFLICT, 0);
    add_vec(0, L_G, L_R, 3, 1, FC_CONFLICT, 0);
    // Dark: 8-cycle dark runs are fine, 9 latches FILTER_TICKS later.
    add_vec(1, L_R, L_R, 1, 0, FC_NONE, 0);
    add_vec(0, L_R, L_R, 2, 0, FC_NONE, 0);
    add_vec(0, L_R, L_DARK, 8, 0, FC_NONE, 0);
    add_vec(0, L_R, L_R, 2, 0, FC_NONE, 0);
    add_vec(0, L_R, L_DARK, 8, 0, FC_NONE, 0);
    add_vec(0, L_R, L_R, 2, 0, FC_NONE, 0);
    add_vec(0, L_R, L_DARK, 9, 0, FC_NONE, 0);
    add_vec(0, L_R, L_DARK, 2, 0, FC_NONE, 0);
    add_vec(0, L_R, L_DARK, 1, 1, FC_DARK, 1);
    // Yellow: a full 10-cycle yellow is fine, a 6-cycle yellow faults.
    add_vec(1, L_R, L_R, 1, 0, FC_NONE, 0);
    add_vec(0, L_R, L_R, 2, 0, FC_NONE, 0);
    add_vec(0, L_Y, L_R, 10, 0, FC_NONE, 0);
    add_vec(0, L_R, L_R, 3, 0, FC_NONE, 0);
    add_vec(0, L_Y, L_R, 6, 0, FC_NONE, 0);
    add_vec(0, L_R, L_R, 1, 0, FC_NONE, 0);
    add_vec(0, L_R, L_R, 1, YEL_EN, YEL_EN ? FC_SHORT_YELLOW : FC_NONE, 0);
    add_vec(0, L_R, L_R, 3, YEL_EN, YEL_EN ? FC_SHORT_YELLOW : FC_NONE, 0);
    // Conflict beats multi-lamp; multi-lamp alone reports the approach.
    add_vec(1, L_R, L_R, 1, 0, FC_NONE, 0);
    add_vec(0, L_RG, L_G, 3, 0, FC_NONE, 0);
    add_vec(0, L_RG, L_G, 1, 1, FC_CONFLICT, 0);
    add_vec(1, L_R, L_R, 1, 0, FC_NONE, 0);
    add_vec(0, L_R, L_RY, 4, 1, FC_MULTI_LAMP, 1);
    add_vec(1, L_R, L_R, 1, 0, FC_NONE, 0);
    add_vec(0, L_RG, L_R, 4, 1, FC_MULTI_LAMP, 0);

    foreach (vecs[i]) begin
      exp_q.push_back({vecs[i].issue, vecs[i].code, vecs[i].appr});
      drive(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].edges);
      check_out($sformatf("vec%0d", i));
    end

    // Reset mid-PENDING: count discarded, full latency applies again.
    drive(1, L_R, L_R, 1);
    drive(0, L_R, L_R, 2);
    drive(0, L_G, L_G, 2);
    check_state("pending_before_reset", ST_PENDING);
    drive(1, L_G, L_G, 1);
    exp_q.push_back({1'b0, FC_NONE, 1'b0});
    check_out("mid_reset_out");
    check_state("mid_reset_state", ST_MONITOR);
    for (int e = 1; e <= 4; e++) begin
      drive(0, L_G, L_G, 1);
      exp_q.push_back({(e == 4), (e == 4) ? FC_CONFLICT : FC_NONE, 1'b0});
      check_out($sformatf("post_reset_edge%0d", e));
    end
    check_state("post_reset_fault", ST_FAULT);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_failed);
    $finish;
  end

endmodule

// File: doc/intersection_conflict_monitor.md
# intersection_conflict_monitor

Independent watchdog on the light outputs of the two approach state machines at one intersection. It samples both lamp sets every clock and latches a fault on any unsafe pattern: conflicting right-of-way, illegal lamp combination, dark approach, or short yellow. It then drives `out_issue`, which feeds `in_issue` of both light state machines and forces them to flashing red.

## Interface
Parameters:
- `FILTER_TICKS`, default 32'd3: number of consecutive cycles a persistent violation must last before it latches. Must be ≥1; a value of 0 behaves as 1.
- `DARK_MAX_TICKS`, default 32'd50000000 (1 s at 50 MHz): longest allowed all-dark run per approach. This covers the flashing-red off phase.
- `MIN_YELLOW_TICKS`, default 32'd250000000 (5 s): minimum yellow duration before red.

Ports:
- `in_clock` input 1: the block's one clock.
- `in_reset` input 1: reset, synchronous and active-high. It is the only way out of FAULT.
- `in_lights_a` input 5: lamps of approach A, bit order {pedestrian, left_turn, yellow, green, red}.
- `in_lights_b` input 5: lamps of approach B, same bit order.
- `out_issue` output 1: fault latched. Drives `in_issue` of both light machines.
- `out_fault_code` output 3: 0 none, 1 conflict, 2 multi-lamp, 3 dark, 4 short yellow.
- `out_fault_approach` output 1: 0 = A, 1 = B. Always 0 for conflict.

## Operation
Input register:
- `in_lights_a` and `in_lights_b` are registered once. All checks use the registered values; call these "samples".

Definitions:
- An approach has **go** when any of green, yellow, left_turn or pedestrian is set in its sample.

Persistent violations, evaluated each cycle:
- Conflict: go(A) and go(B) are both set.
- Multi-lamp: red is set together with any go lamp, or green is set together with yellow.
- Dark: the sample is 5'b0 for more than DARK_MAX_TICKS consecutive cycles. Each approach has its own dark counter. The counter saturates and clears on any lit sample.

Event violation (short yellow):
- Each approach has a yellow counter. It counts consecutive cycles where yellow is the only lamp set, and saturates at MIN_YELLOW_TICKS.
- When the previous sample was yellow-only and the current sample is red-only, the counter is checked. If it is below MIN_YELLOW_TICKS, the fault latches immediately; the filter is bypassed.
- Any other exit from yellow clears the counter with no fault.

State machine (in MONITOR, PENDING, FAULT):
- MONITOR:
  - Any persistent violation → PENDING, with the filter count set to 1.
  - Short-yellow event → FAULT.
- PENDING:
  - No persistent violation → MONITOR, filter count cleared.
  - Filter count reaches FILTER_TICKS → FAULT.
  - Otherwise the filter count increments.
- FAULT:
  - Outputs are held; samples are ignored.
  - Exits only on `in_reset`.

Fault capture:
- On entry to FAULT, the highest-priority active violation is captured.
- Priority order: conflict > multi-lamp > dark > short yellow.
- Within one violation class, A takes priority over B.

## Timing
Reset:
- On `in_reset`, the state goes to MONITOR and all counters are cleared.
- `out_issue` = 0, `out_fault_code` = 0, `out_fault_approach` = 0. The input register is cleared to 0.
- `in_reset` has priority over every other event in the same cycle.

Persistent violation latency:
- Violating inputs are stable before edge 1 and registered at edge 1.
- `out_issue` goes high after edge FILTER_TICKS+1. With the default FILTER_TICKS, that is edge 4.

Short-yellow latency:
- The red-only input is registered at edge k.
- `out_issue` goes high after edge k+1.

Outputs:
- All outputs are registered and change only together on entry to FAULT or on reset.

Boundary conditions:
- A glitch shorter than FILTER_TICKS cycles leaves no trace.
- A violation that drops for one cycle restarts the filter.
- Reset asserted mid-PENDING discards the count.
- If the violation is still present after reset, the full FILTER_TICKS+1 latency applies again.
- All counters are 32 bits and saturating; none wrap.

## Configuration
Macro `CONFLICT_MONITOR_YELLOW_CHECK_EN`:
- Defined: the yellow counters and the short-yellow event are compiled in.
- Undefined: they are removed, and code 4 is never produced.
- All other behaviour is identical in both builds.

## Structure
- Package `conflict_monitor_pkg` holds:
  - the fault code constants;
  - the lamp bit index constants (RED=0 … PEDESTRIAN=4);
  - the state encoding.
- Sub-module `approach_checker`, instantiated once per approach, contains:
  - the multi-lamp decode;
  - the dark counter;
  - the yellow counter and short-yellow event;
  - the go output.
- The top level holds:
  - the input register;
  - the conflict check;
  - the filter and the state machine;
  - fault capture.

## Test plan
All scenarios use FILTER_TICKS=3, DARK_MAX_TICKS=8, MIN_YELLOW_TICKS=10.

- **Conflict:** A=green, B=green held → `out_issue`=1 after edge 4, code=1, approach=0. It stays latched after B returns to red, until `in_reset`.
- **Glitch rejection:** A=green, B=red; B driven green for 2 cycles, then red → `out_issue` stays 0. Repeating with 3 cycles → latches with code 1.
- **Dark and flashing red:** B dark for 8 cycles, then red, repeated → no fault. B dark for 9 cycles → code=3, approach=1, latched FILTER_TICKS cycles after the dark limit is exceeded.
- **Short yellow:** A yellow-only for 6 cycles, then red-only → code=4, approach=0, one edge after red is registered. With the macro undefined → no fault.
- **Simultaneous violations:** A red+green with a conflict present → code=1, since conflict wins over multi-lamp.
- **Reset mid-PENDING:** conflict held for 2 cycles, `in_reset` asserted for 1 cycle, conflict still held → `out_issue` rises 4 edges after reset deasserts.
